// File: rtl/alu_iter.sv
// Iterative unsigned ALU: single-cycle arithmetic/logic ops plus a restoring divider
// that retires one quotient bit per cycle, with a valid/ready handshake on both sides.
module alu_iter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned OP_W  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  alu_op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] rem_out,
    output logic             carry_out,
    output logic             zero_flag,
    output logic             err_flag,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned CNTW = $clog2(WIDTH);

    localparam logic [OP_W-1:0] OpAdd = OP_W'(0);
    localparam logic [OP_W-1:0] OpSub = OP_W'(1);
    localparam logic [OP_W-1:0] OpMul = OP_W'(2);
    localparam logic [OP_W-1:0] OpDiv = OP_W'(3);
    localparam logic [OP_W-1:0] OpAnd = OP_W'(4);
    localparam logic [OP_W-1:0] OpOr  = OP_W'(5);
    localparam logic [OP_W-1:0] OpXor = OP_W'(6);
    localparam logic [OP_W-1:0] OpShl = OP_W'(7);
    localparam logic [OP_W-1:0] OpShr = OP_W'(8);

    typedef enum logic [1:0] {
        StIdle,
        StDivBusy,
        StDone
    } state_e;

    state_e state_q;

    logic [WIDTH-1:0] div_quo_q;
    logic [WIDTH-1:0] div_rem_q;
    logic [WIDTH-1:0] div_dvs_q;
    logic [CNTW-1:0]  cnt_q;

    logic             accept;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_alu;
    logic [WIDTH-1:0]   res_rem;
    logic               res_carry;
    logic               res_err;
    logic               res_div;

    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;

    assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept   = in_valid && in_ready;

    // Result of any op that completes in one cycle; res_div flags a real division.
    always_comb begin
        res_alu   = '0;
        res_rem   = '0;
        res_carry = 1'b0;
        res_err   = 1'b0;
        res_div   = 1'b0;
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        case (alu_op)
            OpAdd: begin
                res_alu   = sum[WIDTH-1:0];
                res_carry = sum[WIDTH];
            end
            OpSub: begin
                res_alu   = diff[WIDTH-1:0];
                res_carry = diff[WIDTH];
            end
            OpMul: begin
                res_alu   = prod[WIDTH-1:0];
                res_carry = |prod[2*WIDTH-1:WIDTH];
            end
            OpDiv: begin
                if (b == '0) begin
                    res_alu = '1;
                    res_rem = a;
                    res_err = 1'b1;
                end else begin
                    res_div = 1'b1;
                end
            end
            OpAnd: res_alu = a & b;
            OpOr:  res_alu = a | b;
            OpXor: res_alu = a ^ b;
            OpShl: res_alu = a << b[SHW-1:0];
            OpShr: res_alu = a >> b[SHW-1:0];
            default: res_err = 1'b1;
        endcase
    end

    // One restoring step: the top bit of trial is the borrow of partial - divisor.
    always_comb begin
        partial = {div_rem_q, div_quo_q[WIDTH-1]};
        trial   = partial - {1'b0, div_dvs_q};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {div_quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = partial[WIDTH-1:0];
            quo_next = {div_quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            alu_out   <= '0;
            rem_out   <= '0;
            carry_out <= 1'b0;
            zero_flag <= 1'b0;
            err_flag  <= 1'b0;
            out_valid <= 1'b0;
            div_quo_q <= '0;
            div_rem_q <= '0;
            div_dvs_q <= '0;
            cnt_q     <= '0;
        end else if (accept) begin
            if (res_div) begin
                state_q   <= StDivBusy;
                out_valid <= 1'b0;
                div_quo_q <= a;
                div_rem_q <= '0;
                div_dvs_q <= b;
                cnt_q     <= '0;
            end else begin
                state_q   <= StDone;
                alu_out   <= res_alu;
                rem_out   <= res_rem;
                carry_out <= res_carry;
                zero_flag <= (res_alu == '0);
                err_flag  <= res_err;
                out_valid <= 1'b1;
            end
        end else begin
            case (state_q)
                StDivBusy: begin
                    div_quo_q <= quo_next;
                    div_rem_q <= rem_next;
                    cnt_q     <= cnt_q + 1'b1;
                    if (cnt_q == CNTW'(WIDTH - 1)) begin
                        state_q   <= StDone;
                        alu_out   <= quo_next;
                        rem_out   <= rem_next;
                        carry_out <= 1'b0;
                        zero_flag <= (quo_next == '0);
                        err_flag  <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                StIdle: ;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter at WIDTH=8; inputs change and outputs are
// sampled on the falling clock edge.
module tb_alu_iter;

    logic       clock;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] alu_op;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_out;
    logic [7:0] rem_out;
    logic       carry_out;
    logic       zero_flag;
    logic       err_flag;
    logic       out_valid;
    logic       out_ready;

    int n_cmp;
    int n_err;

    alu_iter #(
        .WIDTH(8),
        .OP_W (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .alu_op   (alu_op),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_out  (alu_out),
        .rem_out  (rem_out),
        .carry_out(carry_out),
        .zero_flag(zero_flag),
        .err_flag (err_flag),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
        alu_op   = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        #1;
        check("in_ready_at_issue", in_ready, 1);
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic run_vec(input string tag, input logic [3:0] op, input logic [7:0] x,
                           input logic [7:0] y, input logic [7:0] exp_y, input logic exp_c,
                           input logic exp_z);
        issue(op, x, y);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_alu"}, alu_out, exp_y);
        check({tag, "_rem"}, rem_out, 0);
        check({tag, "_carry"}, carry_out, exp_c);
        check({tag, "_zero"}, zero_flag, exp_z);
        check({tag, "_err"}, err_flag, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_ready"}, in_ready, 1);
        check({tag, "_alu"}, alu_out, 0);
        check({tag, "_rem"}, rem_out, 0);
        check({tag, "_carry"}, carry_out, 0);
        check({tag, "_zero"}, zero_flag, 0);
        check({tag, "_err"}, err_flag, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        alu_op    = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_all_zero("reset");

        // ADD with carry out of the top bit
        out_ready = 1'b1;
        run_vec("add_200_100", 4'h0, 8'd200, 8'd100, 8'h2C, 1'b1, 1'b0);
        @(negedge clock);
        check("add_drain_valid", out_valid, 0);
        check("add_drain_ready", in_ready, 1);
        check("add_hold_alu", alu_out, 8'h2C);

        // DIV 200/7: busy for 8 cycles, extra requests during busy are dropped
        issue(4'h3, 8'd200, 8'd7);
        for (int i = 0; i < 8; i++) begin
            check("div_busy_valid", out_valid, 0);
            check("div_busy_ready", in_ready, 0);
            if (i < 4) begin
                alu_op   = 4'h0;
                a        = 8'd3;
                b        = 8'd3;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
        end
        check("div_valid", out_valid, 1);
        check("div_quo", alu_out, 8'd28);
        check("div_rem", rem_out, 8'd4);
        check("div_carry", carry_out, 0);
        check("div_err", err_flag, 0);

        // Divide by zero, then an illegal op accepted back-to-back
        issue(4'h3, 8'd55, 8'd0);
        check("div0_valid", out_valid, 1);
        check("div0_alu", alu_out, 8'hFF);
        check("div0_rem", rem_out, 8'd55);
        check("div0_err", err_flag, 1);
        check("div0_carry", carry_out, 0);
        check("div0_zero", zero_flag, 0);
        issue(4'hF, 8'd9, 8'd3);
        check("ill_valid", out_valid, 1);
        check("ill_alu", alu_out, 0);
        check("ill_rem", rem_out, 0);
        check("ill_err", err_flag, 1);
        check("ill_zero", zero_flag, 1);
        check("ill_carry", carry_out, 0);
        @(negedge clock);

        // MUL held under backpressure, then SUB accepted as the result is taken
        out_ready = 1'b0;
        issue(4'h2, 8'd16, 8'd20);
        alu_op   = 4'h0;
        a        = 8'd1;
        b        = 8'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("mul_hold_valid", out_valid, 1);
            check("mul_hold_alu", alu_out, 8'h40);
            check("mul_hold_carry", carry_out, 1);
            check("mul_hold_ready", in_ready, 0);
            @(negedge clock);
        end
        out_ready = 1'b1;
        issue(4'h1, 8'd5, 8'd9);
        check("sub_valid", out_valid, 1);
        check("sub_alu", alu_out, 8'hFC);
        check("sub_carry", carry_out, 1);
        check("sub_zero", zero_flag, 0);

        // Back-to-back single-cycle ops
        run_vec("and", 4'h4, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
        run_vec("or", 4'h5, 8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0);
        run_vec("xor", 4'h6, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0);
        run_vec("shl", 4'h7, 8'h81, 8'h0A, 8'h04, 1'b0, 1'b0);
        run_vec("shr", 4'h8, 8'h81, 8'h0B, 8'h10, 1'b0, 1'b0);
        run_vec("sub_eq", 4'h1, 8'd9, 8'd9, 8'h00, 1'b0, 1'b1);
        run_vec("add_wrap", 4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
        run_vec("mul_fit", 4'h2, 8'd15, 8'd17, 8'hFF, 1'b0, 1'b0);
        @(negedge clock);

        // Reset on the 4th DIV_BUSY cycle discards the division
        issue(4'h3, 8'd200, 8'd7);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_all_zero("div_reset");
        repeat (8) @(negedge clock);
        check("div_reset_no_result", out_valid, 0);
        run_vec("add_1_1", 4'h0, 8'd1, 8'd1, 8'd2, 1'b0, 1'b0);
        @(negedge clock);

        // Reset wins over a same-edge request
        reset    = 1'b1;
        alu_op   = 4'h0;
        a        = 8'd3;
        b        = 8'd4;
        in_valid = 1'b1;
        @(negedge clock);
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        check_all_zero("reset_prio");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 4..32.
REQ-002 Parameter OP_W, default 4, width of the operation select.
REQ-003 Ports use one clock and one reset; reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 a  input  WIDTH  first operand (dividend for DIV).
REQ-007 b  input  WIDTH  second operand (divisor for DIV).
REQ-008 alu_op  input  OP_W  operation select.
REQ-009 in_valid  input  1  request present on a/b/alu_op.
REQ-010 in_ready  output  1  block can accept a request this cycle.
REQ-011 alu_out  output  WIDTH  result (quotient for DIV).
REQ-012 rem_out  output  WIDTH  DIV remainder; 0 for all other ops.
REQ-013 carry_out  output  1  carry/borrow/mul-overflow flag.
REQ-014 zero_flag  output  1  alu_out == 0.
REQ-015 err_flag  output  1  divide-by-zero or illegal op.
REQ-016 out_valid  output  1  result and flags valid.
REQ-017 out_ready  input  1  consumer takes the result this cycle.

Function
REQ-018 Unsigned ops: 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR, 0110 XOR, 0111 SHL by b[log2(WIDTH)-1:0], 1000 SHR (logical) by the same field; all other codes are illegal.
REQ-019 Acceptance occurs on a rising edge with in_valid && in_ready; a, b and alu_op are registered then, and later input changes do not affect the op.
REQ-020 in_valid while in_ready=0 is ignored and is not queued.
REQ-021 FSM states: IDLE, DIV_BUSY, DONE.
REQ-022 IDLE: in_ready=1, out_valid=0; accept a non-DIV op, a DIV with b==0, or an illegal op -> DONE; accept a DIV with b!=0 -> DIV_BUSY.
REQ-023 DIV_BUSY: restoring division, one quotient bit per cycle for exactly WIDTH cycles, then -> DONE; in_ready=0, out_valid=0.
REQ-024 DONE: out_valid=1 and outputs held stable until out_ready=1.
REQ-025 DONE with out_ready=1 and no acceptance -> IDLE.
REQ-026 in_ready is 1 in IDLE and in DONE when out_ready=1; in_ready is 0 otherwise.
REQ-027 DONE with out_ready=1 and a same-cycle acceptance (back-to-back) -> DONE or DIV_BUSY per REQ-022.
REQ-028 Latency: out_valid rises 1 cycle after acceptance for single-cycle ops, and WIDTH cycles after acceptance for DIV with b!=0.
REQ-029 ADD: alu_out = (a+b) mod 2^WIDTH; carry_out = bit WIDTH of the sum.
REQ-030 SUB: alu_out = (a-b) mod 2^WIDTH; carry_out = 1 iff a<b (borrow).
REQ-031 MUL: alu_out = low WIDTH bits of the product; carry_out = 1 iff the high WIDTH bits are nonzero.
REQ-032 DIV with b!=0: alu_out = a/b, rem_out = a%b, carry_out = 0.
REQ-033 DIV with b==0: alu_out = all ones, rem_out = a, err_flag = 1, latency 1.
REQ-034 Logic and shift ops: carry_out = 0.
REQ-035 Illegal op: alu_out = 0, rem_out = 0, carry_out = 0, err_flag = 1, zero_flag = 1, latency 1.
REQ-036 zero_flag reflects the registered alu_out, including in the illegal-op case.
REQ-037 Outputs change only on an acceptance-driven transition into DONE; they are otherwise stable.

Reset
REQ-038 Reset asserted at a rising edge -> next state IDLE.
REQ-039 Reset values: alu_out=0, rem_out=0, carry_out=0, zero_flag=0, err_flag=0, out_valid=0.
REQ-040 Reset values: in_ready=1 (state IDLE), and any division in progress is discarded.
REQ-041 Reset has priority over acceptance in the same cycle; no request is accepted on a reset edge.

Verification (WIDTH=8)
REQ-042 ADD a=200 b=100 -> next cycle out_valid=1, alu_out=0x2C, carry_out=1, zero_flag=0.
REQ-043 DIV a=200 b=7 -> out_valid exactly 8 cycles after acceptance, alu_out=28, rem_out=4, in_ready=0 throughout DIV_BUSY.
REQ-044 DIV a=55 b=0 -> next cycle alu_out=0xFF, rem_out=55, err_flag=1; op 4'b1111 -> alu_out=0, err_flag=1, zero_flag=1.
REQ-045 MUL a=16 b=20 with out_ready=0 for 3 cycles -> alu_out=0x40 and carry_out=1 held stable, in_ready=0; SUB 5-9 presented with out_ready=1 is accepted that same cycle -> alu_out=0xFC, carry_out=1.
REQ-046 Reset asserted on the 4th cycle of DIV_BUSY -> next cycle IDLE, out_valid=0, in_ready=1, all outputs 0; a following ADD 1+1 -> alu_out=2.
